// File: rtl/pe_nic.sv
// pe_nic: network interface between a processing element and one router PE port.
//
// One 64-bit packet slot per direction. The processor writes the output slot
// (addr 10), which is injected into the router once the router is ready and
// the packet's virtual-channel bit matches the router polarity. The router
// ejects packets into the input slot, which the processor reads (addr 00).
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   addr              register select: 00 ibuf, 01 ibuf status, 10 obuf, 11 obuf status
//   d_in, d_out       processor write data; registered read data (1-cycle latency)
//   nicEn, nicEnWr    register access enable; 1 = write, 0 = read
//   net_si/ri/di      router send-in, ready-in, data-in (from router peso/peri/pedo)
//   net_so/ro/do      send-out, ready-out, data-out (to router pesi/pero/pedi)
//   net_polarity      router virtual-channel polarity
//   nic_irq           input-packet interrupt
//
// Optional feature: define PE_NIC_IRQ_EN to make nic_irq a registered copy of
// the input-buffer-full flag; otherwise nic_irq is tied to 0.
module pe_nic #(
    parameter int DATA_W = 64,
    parameter int VC_BIT = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicEnWr,
    input  logic              net_si,
    input  logic              net_ri,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_so,
    output logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity,
    output logic              nic_irq
);
    logic [DATA_W-1:0] ibuf_q, ibuf_d, obuf_q, obuf_d, d_out_q, d_out_d;
    logic              ibuf_full_q, ibuf_full_d, obuf_full_q, obuf_full_d;
    logic              rd, wr, eject;

    assign net_ro = ~ibuf_full_q;
    assign net_so = obuf_full_q & net_ri & (obuf_q[VC_BIT] == net_polarity);
    assign net_do = obuf_q;
    assign d_out  = d_out_q;

    always_comb begin
        rd          = nicEn & ~nicEnWr;
        wr          = nicEn & nicEnWr;
        eject       = net_si & net_ro;
        ibuf_d      = eject ? net_di : ibuf_q;
        // An ejection only happens when the slot is empty, so it wins over a
        // coincident read of an already-empty slot.
        ibuf_full_d = eject ? 1'b1 : (rd && addr == 2'b00) ? 1'b0 : ibuf_full_q;
        // The pre-edge full flag gates the write, so a write at the departure
        // edge is dropped.
        obuf_d      = (wr && addr == 2'b10 && !obuf_full_q) ? d_in : obuf_q;
        obuf_full_d = (wr && addr == 2'b10 && !obuf_full_q) ? 1'b1 :
                      net_so ? 1'b0 : obuf_full_q;
        d_out_d     = !rd ? d_out_q :
                      addr[1] ? (addr[0] ? {{(DATA_W-1){1'b0}}, obuf_full_q} : obuf_q) :
                                (addr[0] ? {{(DATA_W-1){1'b0}}, ibuf_full_q} : ibuf_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ibuf_q      <= '0;
            ibuf_full_q <= 1'b0;
            obuf_q      <= '0;
            obuf_full_q <= 1'b0;
            d_out_q     <= '0;
        end else begin
            ibuf_q      <= ibuf_d;
            ibuf_full_q <= ibuf_full_d;
            obuf_q      <= obuf_d;
            obuf_full_q <= obuf_full_d;
            d_out_q     <= d_out_d;
        end
    end

`ifdef PE_NIC_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d   = ibuf_full_q;
    assign nic_irq = irq_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end
`else
    assign nic_irq = 1'b0;
`endif
endmodule

// File: tb/tb_pe_nic.sv
// tb_pe_nic: scoreboard bench for pe_nic; reads and injections are checked by monitors.
module tb_pe_nic;
`ifdef PE_NIC_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  addr = '0;
    logic [63:0] d_in = '0, d_out, net_di = '0, net_do;
    logic        nicEn = 1'b0, nicEnWr = 1'b0, net_si = 1'b0, net_ri = 1'b0;
    logic        net_so, net_ro, net_polarity = 1'b0, nic_irq;
    logic [63:0] rq[$];
    logic [63:0] iq[$];
    logic        rd_pend = 1'b0;
    int          checks = 0, errors = 0;

    pe_nic dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicEnWr(nicEnWr), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity), .nic_irq(nic_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        @(negedge clk);
        nicEn = 1'b1; nicEnWr = 1'b1; addr = a; d_in = d;
    endtask

    task automatic rd(input logic [1:0] a, input logic [63:0] exp);
        @(negedge clk);
        nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
        rq.push_back(exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            nicEn = 1'b0;
        end
    endtask

    task automatic ej(input logic [63:0] d);
        @(negedge clk);
        nicEn = 1'b0; net_si = 1'b1; net_di = d;
    endtask

    // Monitor: compares registered read data and every injected packet.
    always begin
        @(negedge clk);
        #1;
        if (rd_pend) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected actual=%h expected=none", d_out);
            end else chk("rd_data", d_out, rq.pop_front());
        end
        rd_pend = reset && nicEn && !nicEnWr;
        if (reset && net_so) begin
            if (iq.size() == 0) begin
                checks++; errors++;
                $display("FAIL inj_unexpected actual=%h expected=none", net_do);
            end else chk("inj_data", net_do, iq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst_so", net_so, 0);
        chk("rst_ro", net_ro, 1);
        chk("rst_do", net_do, 0);
        chk("rst_dout", d_out, 0);
        chk("rst_irq", nic_irq, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        // injection with matching polarity
        net_ri = 1'b1; net_polarity = 1'b0;
        wr(2'b10, 64'h200200000000FA50);
        iq.push_back(64'h200200000000FA50);
        idle(1); #1;
        chk("inj_so", net_so, 1);
        chk("inj_do", net_do, 64'h200200000000FA50);
        rd(2'b11, 0);
        idle(1); #1;
        chk("inj_so_after", net_so, 0);
        // polarity mismatch holds the packet
        wr(2'b10, 64'h8000000000000001);
        repeat (3) begin
            idle(1); #1;
            chk("pol_wait_so", net_so, 0);
        end
        idle(1); net_polarity = 1'b1; #1;
        chk("pol_match_so", net_so, 1);
        iq.push_back(64'h8000000000000001);
        idle(1); #1;
        chk("pol_sent_once", net_so, 0);
        // ejection and read
        ej(64'h4002000000006840);
        idle(1); net_si = 1'b0; #1;
        chk("ej_ro", net_ro, 0);
        rd(2'b01, 1); #1;
        chk("ej_irq_set", nic_irq, IRQ_EN);
        rd(2'b00, 64'h4002000000006840);
        idle(1); #1;
        chk("ej_ro_back", net_ro, 1);
        idle(1); #1;
        chk("ej_irq_clr", nic_irq, 0);
        // held send while full: no overwrite, captured after the read
        ej(64'h1111);
        idle(1); net_di = 64'hABCDEF; #1;
        chk("hold_ro", net_ro, 0);
        idle(1);
        rd(2'b00, 64'h1111);
        idle(1); #1;
        chk("hold_ro_free", net_ro, 1);
        idle(1); net_si = 1'b0; #1;
        chk("hold_ro_full", net_ro, 0);
        rd(2'b01, 1); #1;
        chk("hold_irq_set", nic_irq, IRQ_EN);
        rd(2'b00, 64'hABCDEF);
        idle(2); #1;
        chk("hold_irq_clr", nic_irq, 0);
        // write dropped while full, including at the departure edge
        net_ri = 1'b0;
        wr(2'b10, 64'h00000000CAFE0001);
        wr(2'b10, 64'h12345678);
        rd(2'b10, 64'h00000000CAFE0001);
        rd(2'b11, 1);
        wr(2'b10, 64'h5555);
        net_ri = 1'b1; net_polarity = 1'b0;
        iq.push_back(64'h00000000CAFE0001);
        rd(2'b11, 0);
        net_ri = 1'b0;
        rd(2'b10, 64'h00000000CAFE0001);
        // asynchronous reset mid-operation
        wr(2'b10, 64'h0123);
        ej(64'h77);
        idle(1); net_si = 1'b0;
        rd(2'b10, 64'h0123);
        idle(1); #3;
        chk("pre_rst_ro", net_ro, 0);
        reset = 1'b0; net_ri = 1'b1; net_polarity = 1'b0; #1;
        chk("mid_rst_so", net_so, 0);
        chk("mid_rst_ro", net_ro, 1);
        chk("mid_rst_dout", d_out, 0);
        chk("mid_rst_do", net_do, 0);
        chk("mid_rst_irq", nic_irq, 0);
        @(negedge clk);
        reset = 1'b1; net_ri = 1'b0;
        rd(2'b01, 0);
        rd(2'b11, 0);
        rd(2'b10, 0);
        rd(2'b00, 0);
        idle(2);
        chk("rq_empty", rq.size(), 0);
        chk("iq_empty", iq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_nic.md
Name: pe_nic

Overview:
- Network interface controller between a processing element (PE) and the PE port of one router.
- Processor side: 2-bit addressed register port with 4 registers.
  - Write path: output channel buffer. Its packet is injected into the router (router pesi/pedi/peri).
  - Read path: input channel buffer. It holds packets ejected by the router (router peso/pedo/pero).
- One 64-bit packet slot per direction. Injection is gated by the router's virtual-channel polarity.

Parameters:
- DATA_W, 64, packet and processor data width.
- VC_BIT, 63, packet bit that selects the virtual channel; compared against net_polarity.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- addr  in  2  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  in  DATA_W  processor write data.
- d_out  out  DATA_W  processor read data, registered.
- nicEn  in  1  register access enable.
- nicEnWr  in  1  1 = write, 0 = read (qualified by nicEn).
- net_si  in  1  router send-in, from router peso.
- net_ri  in  1  router ready-in, from router peri.
- net_di  in  DATA_W  router data-in, from router pedo.
- net_so  out  1  send-out, to router pesi.
- net_ro  out  1  ready-out, to router pero.
- net_do  out  DATA_W  data-out, to router pedi.
- net_polarity  in  1  router polarity_out.
- nic_irq  out  1  interrupt, see Optional Feature.

Behaviour:
- State: ibuf[DATA_W], ibuf_full, obuf[DATA_W], obuf_full, d_out register.
- Reset (async, while reset=0): ibuf=0, ibuf_full=0, obuf=0, obuf_full=0, d_out=0. As a result net_so=0, net_ro=1, net_do=0, nic_irq=0.
- Ejection (router -> NIC):
  - net_ro = ~ibuf_full (combinational from register).
  - On an edge with net_si=1 and net_ro=1: ibuf<=net_di, ibuf_full<=1.
  - net_si while net_ro=0 is ignored; the router must hold.
- Injection (NIC -> router):
  - net_do = obuf.
  - net_so = obuf_full & net_ri & (obuf[VC_BIT]==net_polarity), combinational.
  - On an edge with net_so=1: obuf_full<=0. obuf keeps its value.
  - Packet waits while polarity mismatches or net_ri=0. No timeout.
- Processor read (nicEn=1, nicEnWr=0): d_out updates at the edge, valid the following cycle (1-cycle latency).
  - addr 00: d_out<=ibuf; ibuf_full<=0 at the same edge. Reading while empty returns stale ibuf and leaves ibuf_full=0.
  - addr 01: d_out<={0..., ibuf_full}.
  - addr 10: d_out<=obuf.
  - addr 11: d_out<={0..., obuf_full}.
  - nicEn=0: d_out holds its value.
- Processor write (nicEn=1, nicEnWr=1):
  - addr 10 with obuf_full=0 (pre-edge value): obuf<=d_in, obuf_full<=1.
  - addr 10 with obuf_full=1: write is dropped, even if the packet departs at that same edge.
  - Writes to 00/01/11 are ignored; d_out is unchanged.
- Simultaneous events:
  - Read of addr 00 at the edge where ibuf_full=1: no ejection can coincide, because net_ro=0. net_ro returns to 1 the next cycle.
  - Write and injection never touch the same slot in one edge; see the drop rule above.
- Earliest new injection: the cycle after the write (obuf_full registered).
- Throughput is one packet per two cycles per direction at best.

Optional Feature:
- Macro PE_NIC_IRQ_EN.
- Defined: nic_irq is a registered output, set to 1 the edge after ibuf_full becomes 1. It clears the edge after ibuf_full clears. Reset value 0.
- Undefined: nic_irq is tied to 0, and the port remains for interface stability.

Test Plan:
- Reset mid-operation: obuf_full=1 and ibuf_full=1, then drop reset to 0 → immediately net_so=0, net_ro=1, d_out=0; status reads return 0.
- Write addr 10 d_in=64'h200200000000FA50 with net_ri=1 and net_polarity=0 → net_so=1 the next cycle with net_do=64'h200200000000FA50; status 11 reads 0 after the send edge.
- Write 64'h8000000000000001 with net_polarity=0 held for 3 cycles → net_so=0. Toggle net_polarity=1 → net_so=1 in that cycle; sent once.
- Drive net_si=1, net_di=64'h4002000000006840 → net_ro=0 the next cycle; status 01 read returns 1. Read addr 00 → d_out=64'h4002000000006840 one cycle later; net_ro=1 the following cycle.
- With the input buffer full, hold net_si=1 and net_di=64'hABCDEF → no overwrite. After reading addr 00, ibuf=64'hABCDEF is captured next. With PE_NIC_IRQ_EN, nic_irq is 1 one cycle after each capture and 0 one cycle after each read.
- With obuf_full=1 and net_ri=0, write 64'h12345678 → dropped; addr 10 still returns the original packet.
